// File: rtl/diff_tx_if.sv
// diff_tx_if: code/trigger request and serial line status of the pulse-width frame transmitter
interface diff_tx_if;
    logic [25:0] code_in;
    logic        trigger_in;
    logic        data_out;
    logic        busy_out;
    logic [2:0]  state_out;
    modport master (output code_in, trigger_in, input data_out, busy_out, state_out);
    modport slave (input code_in, trigger_in, output data_out, busy_out, state_out);
endinterface

// File: rtl/diff_tx.sv
// diff_tx: serialises a 26-bit code MSB first as a single-wire pulse-width frame
module diff_tx #(
    parameter int DATA_PERIOD               = 20,
    parameter int HALF_DATA_PERIOD          = 10,
    parameter int QUARTER_DATA_PERIOD       = 5,
    parameter int THREE_QUARTER_DATA_PERIOD = 15,
    parameter int GUARD_PERIOD              = 10
) (
    input logic      clk_in,
    input logic      rst_in,
    diff_tx_if.slave bus
);
    localparam int MAX_PHASE = (DATA_PERIOD > GUARD_PERIOD) ? DATA_PERIOD : GUARD_PERIOD;
    localparam int CW = $clog2(MAX_PHASE + 1);
    localparam logic [CW-1:0] L_H = CW'(HALF_DATA_PERIOD);
    localparam logic [CW-1:0] L_Q = CW'(QUARTER_DATA_PERIOD);
    localparam logic [CW-1:0] L_T = CW'(THREE_QUARTER_DATA_PERIOD);
    localparam logic [CW-1:0] L_G = CW'(GUARD_PERIOD);

    if (QUARTER_DATA_PERIOD + THREE_QUARTER_DATA_PERIOD != DATA_PERIOD ||
        2 * HALF_DATA_PERIOD != DATA_PERIOD) begin : g_param_check
        $error("diff_tx: phase lengths do not add up to DATA_PERIOD");
    end

    typedef enum logic [2:0] {IDLE, SL, SH, DL, DH, EL, GUARD} state_t;

    state_t        state;
    logic [25:0]   buffer;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len;
    logic [4:0]    idx;
    logic          data_r;
    logic          busy_r;
    logic          cur_bit;

    // length of the phase being held in the current state
    always_comb begin
        cur_bit = buffer[idx];
        len = (state == DL) ? (cur_bit ? L_T : L_Q) :
              (state == DH) ? (cur_bit ? L_Q : L_T) :
              (state == GUARD) ? L_G : L_H;
    end

    // frame sequencer: every phase holds its level for exactly len cycles
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            buffer <= '0;
            cnt    <= '0;
            idx    <= 5'd25;
            data_r <= 1'b1;
            busy_r <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.trigger_in) begin
                buffer <= bus.code_in;
                idx    <= 5'd25;
                data_r <= 1'b0;
                busy_r <= 1'b1;
                cnt    <= CW'(1);
                state  <= SL;
            end
        end else if (cnt != len) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= CW'(1);
            case (state)
                SL: begin
                    state  <= SH;
                    data_r <= 1'b1;
                end
                SH: begin
                    state  <= DL;
                    data_r <= 1'b0;
                end
                DL: begin
                    state  <= DH;
                    data_r <= 1'b1;
                end
                DH: begin
                    state  <= (idx == 5'd0) ? EL : DL;
                    idx    <= (idx == 5'd0) ? idx : idx - 5'd1;
                    data_r <= 1'b0;
                end
                EL: begin
                    state  <= GUARD;
                    data_r <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_r;
    assign bus.busy_out  = busy_r;
    assign bus.state_out = state;
endmodule
